// File: rtl/sdio_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : sdio_cmd_engine
// Purpose  : Sends one SD command frame on CMD and collects/checks the response.
// Revision : 1.0
// ============================================================================
module sdio_cmd_engine #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic         rstn,
   input  logic         sd_clk,
   input  logic         cmd_sd_rst,
   input  logic         cmd_start,
   input  logic [5:0]   cmd_index,
   input  logic [31:0]  cmd_arg,
   input  logic [1:0]   resp_type,
   input  logic         cmd_in,
   output logic         cmd_out,
   output logic         cmd_oe,
   output logic [127:0] resp,
   output logic         cmd_busy,
   output logic         cmd_done_event,
   output logic         cmd_index_err_event,
   output logic         cmd_end_err_event,
   output logic         cmd_crc_err_event,
   output logic         cmd_timeout_err_event
);

   localparam int                c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES);
   localparam logic [c_TO_W-1:0] c_TO_ONE = c_TO_W'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_TX   = 3'd1,
      S_WAIT = 3'd2,
      S_RX   = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
   endfunction

   function automatic logic [6:0] crc7_bits(input logic [39:0] d);
      logic [6:0] c;
      c = 7'd0;
      for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
      return c;
   endfunction

   state_t              r_state;
   logic [47:0]         r_tx;
   logic [127:0]        r_rx;
   logic [6:0]          r_crc;
   logic [7:0]          r_bit_cnt;
   logic [c_TO_W-1:0]   r_to_cnt;
   logic                r_to_flag;
   logic [5:0]          r_index;
   logic [1:0]          r_type;
   logic                r_out;
   logic                r_oe;
   logic                r_busy;
   logic [127:0]        r_resp;
   logic                r_done_ev;
   logic                r_idx_ev;
   logic                r_end_ev;
   logic                r_crc_ev;
   logic                r_to_ev;

   logic [39:0]         w_tx_head;
   logic [6:0]          w_tx_crc;
   logic [47:0]         w_frame;
   logic [7:0]          w_bit_next;
   logic [7:0]          w_rx_len;
   logic                w_crc_en;
   logic [c_TO_W-1:0]   w_to_next;

   assign w_tx_head  = {2'b01, cmd_index, cmd_arg};
   assign w_tx_crc   = crc7_bits(w_tx_head);
   assign w_frame    = {w_tx_head, w_tx_crc, 1'b1};
   assign w_bit_next = r_bit_cnt + 8'd1;
   assign w_rx_len   = (r_type == 2'd2) ? 8'd136 : 8'd48;
   assign w_to_next  = r_to_cnt + c_TO_ONE;

   // R136 CRC skips the start/transmission/reserved byte (received bits 1..8)
   assign w_crc_en   = (r_type == 2'd2) ? (w_bit_next >= 8'd9 && w_bit_next <= 8'd128)
                                        : (w_bit_next <= 8'd40);

   always_ff @(posedge sd_clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_tx      <= '0;
         r_rx      <= '0;
         r_crc     <= '0;
         r_bit_cnt <= '0;
         r_to_cnt  <= '0;
         r_to_flag <= 1'b0;
         r_index   <= '0;
         r_type    <= '0;
         r_out     <= 1'b1;
         r_oe      <= 1'b0;
         r_busy    <= 1'b0;
         r_resp    <= '0;
         r_done_ev <= 1'b0;
         r_idx_ev  <= 1'b0;
         r_end_ev  <= 1'b0;
         r_crc_ev  <= 1'b0;
         r_to_ev   <= 1'b0;
      end else begin
         r_done_ev <= 1'b0;
         r_idx_ev  <= 1'b0;
         r_end_ev  <= 1'b0;
         r_crc_ev  <= 1'b0;
         r_to_ev   <= 1'b0;
         if (cmd_sd_rst) begin
            r_state   <= S_IDLE;
            r_oe      <= 1'b0;
            r_out     <= 1'b1;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_to_flag <= 1'b0;
            r_busy    <= 1'b0;
         end else begin
            // busy trails the state by one edge so it still covers the event cycle
            r_busy <= (r_state != S_IDLE);
            case (r_state)
               S_IDLE: begin
                  if (cmd_start) begin
                     r_index   <= cmd_index;
                     r_type    <= resp_type;
                     r_out     <= w_frame[47];
                     r_tx      <= {w_frame[46:0], 1'b0};
                     r_oe      <= 1'b1;
                     r_bit_cnt <= 8'd1;
                     r_to_flag <= 1'b0;
                     r_busy    <= 1'b1;
                     r_state   <= S_TX;
                  end
               end
               S_TX: begin
                  if (r_bit_cnt == 8'd48) begin
                     r_oe      <= 1'b0;
                     r_out     <= 1'b1;
                     r_bit_cnt <= '0;
                     r_to_cnt  <= '0;
                     r_state   <= (r_type == 2'd0) ? S_FIN : S_WAIT;
                  end else begin
                     r_out     <= r_tx[47];
                     r_tx      <= {r_tx[46:0], 1'b0};
                     r_bit_cnt <= w_bit_next;
                  end
               end
               S_WAIT: begin
                  if (!cmd_in) begin
                     r_rx      <= '0;
                     r_crc     <= '0;
                     r_bit_cnt <= 8'd1;
                     r_state   <= S_RX;
                  end else if (w_to_next == c_TO_MAX) begin
                     r_to_cnt  <= w_to_next;
                     r_to_flag <= 1'b1;
                     r_state   <= S_FIN;
                  end else begin
                     r_to_cnt  <= w_to_next;
                  end
               end
               S_RX: begin
                  r_rx      <= {r_rx[126:0], cmd_in};
                  r_bit_cnt <= w_bit_next;
                  if (w_crc_en) r_crc <= crc7_step(r_crc, cmd_in);
                  if (w_bit_next == w_rx_len) r_state <= S_FIN;
               end
               S_FIN: begin
                  r_state   <= S_IDLE;
                  r_bit_cnt <= '0;
                  r_to_cnt  <= '0;
                  r_to_flag <= 1'b0;
                  if (r_to_flag) begin
                     r_to_ev <= 1'b1;
                  end else begin
                     r_done_ev <= 1'b1;
                     if (r_type != 2'd0) begin
                        r_end_ev <= ~r_rx[0];
                        r_crc_ev <= (r_type != 2'd3) && (r_rx[7:1] != r_crc);
                        r_idx_ev <= (r_type == 2'd1) && (r_rx[45:40] != r_index);
                        r_resp   <= (r_type == 2'd2) ? r_rx : {96'd0, r_rx[39:8]};
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign cmd_out               = r_out;
   assign cmd_oe                = r_oe;
   assign resp                  = r_resp;
   assign cmd_busy              = r_busy;
   assign cmd_done_event        = r_done_ev;
   assign cmd_index_err_event   = r_idx_ev;
   assign cmd_end_err_event     = r_end_ev;
   assign cmd_crc_err_event     = r_crc_ev;
   assign cmd_timeout_err_event = r_to_ev;

endmodule
`default_nettype wire

// File: tb/tb_sdio_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdio_cmd_engine
// Purpose  : Self-checking bench for sdio_cmd_engine against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_sdio_cmd_engine;

   localparam int TO = 64;

   logic         rstn, sd_clk, cmd_sd_rst, cmd_start, cmd_in;
   logic [5:0]   cmd_index;
   logic [31:0]  cmd_arg;
   logic [1:0]   resp_type;
   logic         cmd_out, cmd_oe, cmd_busy;
   logic [127:0] resp;
   logic         done_ev, idx_ev, end_ev, crc_ev, to_ev;

   int           checks = 0;
   int           errors = 0;
   logic [127:0] exp_resp = '0;

   logic [47:0]  obs_tx;
   bit           obs_oe_ok;
   logic         obs_busy0;
   int           obs_ev_cyc, obs_ev_cnt, obs_idle;
   logic [4:0]   obs_ev;
   logic [127:0] obs_resp;

   sdio_cmd_engine #(.TIMEOUT_CYCLES(TO)) dut (
      .rstn                  (rstn),
      .sd_clk                (sd_clk),
      .cmd_sd_rst            (cmd_sd_rst),
      .cmd_start             (cmd_start),
      .cmd_index             (cmd_index),
      .cmd_arg               (cmd_arg),
      .resp_type             (resp_type),
      .cmd_in                (cmd_in),
      .cmd_out               (cmd_out),
      .cmd_oe                (cmd_oe),
      .resp                  (resp),
      .cmd_busy              (cmd_busy),
      .cmd_done_event        (done_ev),
      .cmd_index_err_event   (idx_ev),
      .cmd_end_err_event     (end_ev),
      .cmd_crc_err_event     (crc_ev),
      .cmd_timeout_err_event (to_ev)
   );

   initial sd_clk = 1'b0;
   always #5 sd_clk = ~sd_clk;

   // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1, over v[hi:lo]
   function automatic logic [6:0] m_crc7(input logic [135:0] v, input int hi, input int lo);
      logic [7:0] r;
      r = 8'h00;
      for (int i = hi; i >= lo - 7; i--) begin
         r = {r[6:0], (i >= lo) ? v[i] : 1'b0};
         if (r[7]) r = r ^ 8'h89;
      end
      return r[6:0];
   endfunction

   function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [135:0] v;
      v = {88'd0, 2'b01, idx, arg, 8'h00};
      v[7:1] = m_crc7(v, 47, 8);
      v[0] = 1'b1;
      return v[47:0];
   endfunction

   function automatic logic [135:0] mk_r48(input logic [5:0] idx, input logic [31:0] arg,
                                           input logic [6:0] flip, input logic endb);
      logic [135:0] v;
      v = {88'd0, 2'b00, idx, arg, 8'h00};
      v[7:1] = m_crc7(v, 47, 8) ^ flip;
      v[0] = endb;
      return v;
   endfunction

   function automatic logic [135:0] mk_r136(input logic [127:0] csd, input logic [6:0] flip,
                                            input logic endb);
      logic [135:0] v;
      v = {2'b00, 6'h3F, csd[127:8], 8'h00};
      v[7:1] = m_crc7(v, 127, 8) ^ flip;
      v[0] = endb;
      return v;
   endfunction

   // Launches one command, plays the response back and records what the DUT did.
   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                          input logic [135:0] rsp, input int rsp_len, input int gap, input int mid_k);
      int first;
      first = 49 + gap;
      obs_tx = '0; obs_oe_ok = 1'b1; obs_ev_cyc = -1; obs_ev = '0; obs_ev_cnt = 0;
      obs_idle = -1; obs_resp = '0;
      cmd_index = idx; cmd_arg = arg; resp_type = typ; cmd_in = 1'b1; cmd_start = 1'b1;
      @(posedge sd_clk); #1;
      cmd_start = 1'b0;
      obs_busy0 = cmd_busy;
      for (int k = 0; k < 400; k++) begin
         if (k > 0) begin
            @(posedge sd_clk); #1;
         end
         cmd_start = 1'b0;
         if (k <= 47) begin
            obs_tx[47-k] = cmd_out;
            if (cmd_oe !== 1'b1) obs_oe_ok = 1'b0;
         end else if (k == 48 && (cmd_oe !== 1'b0 || cmd_out !== 1'b1)) begin
            obs_oe_ok = 1'b0;
         end
         if ({done_ev, idx_ev, end_ev, crc_ev, to_ev} != 5'b0) begin
            if (obs_ev_cyc < 0) begin
               obs_ev_cyc = k;
               obs_ev     = {done_ev, idx_ev, end_ev, crc_ev, to_ev};
               obs_resp   = resp;
            end
            obs_ev_cnt++;
         end
         if (cmd_busy === 1'b0) begin
            obs_idle = k;
            break;
         end
         cmd_in = 1'b1;
         if (rsp_len > 0 && k + 1 >= first && k + 1 < first + rsp_len)
            cmd_in = rsp[rsp_len - 1 - (k + 1 - first)];
         if (k == mid_k) begin
            cmd_start = 1'b1; cmd_index = ~idx; cmd_arg = ~arg; resp_type = typ ^ 2'd1;
         end
      end
      cmd_in = 1'b1;
   endtask

   task automatic test_reset;
      rstn = 1'b0; cmd_sd_rst = 1'b0; cmd_start = 1'b0; cmd_in = 1'b1;
      cmd_index = '0; cmd_arg = '0; resp_type = '0;
      repeat (3) @(posedge sd_clk);
      #1;
      checks++;
      if ({cmd_out, cmd_oe, cmd_busy} !== 3'b100) begin
         errors++; $display("FAIL reset_ctrl: got out/oe/busy=%b expected 100", {cmd_out, cmd_oe, cmd_busy});
      end
      rstn = 1'b1;
      @(posedge sd_clk); #1;
      checks++;
      if (resp !== 128'd0) begin
         errors++; $display("FAIL reset_resp: got %h expected 0", resp);
      end
      checks++;
      if ({done_ev, idx_ev, end_ev, crc_ev, to_ev, cmd_oe, cmd_busy} !== 7'b0 || cmd_out !== 1'b1) begin
         errors++; $display("FAIL reset_idle: got ev=%b oe=%b busy=%b out=%b expected 0/0/0/1",
                            {done_ev, idx_ev, end_ev, crc_ev, to_ev}, cmd_oe, cmd_busy, cmd_out);
      end
   endtask

   task automatic test_cmd0;
      run_cmd(6'd0, 32'h0, 2'd0, '0, 0, 0, -1);
      checks++;
      if (obs_busy0 !== 1'b1) begin
         errors++; $display("FAIL cmd0_busy: got %b expected 1", obs_busy0);
      end
      checks++;
      if (obs_tx !== 48'h400000000095 || !obs_oe_ok) begin
         errors++; $display("FAIL cmd0_frame: got %h oe_ok=%0d expected 400000000095 oe_ok=1", obs_tx, obs_oe_ok);
      end
      checks++;
      if (obs_ev_cyc != 49 || obs_ev !== 5'b10000 || obs_ev_cnt != 1 || obs_idle != 50) begin
         errors++; $display("FAIL cmd0_done: got cyc=%0d ev=%b n=%0d idle=%0d expected 49 10000 1 50",
                            obs_ev_cyc, obs_ev, obs_ev_cnt, obs_idle);
      end
   endtask

   task automatic test_cmd8;
      run_cmd(6'd8, 32'h1AA, 2'd1, mk_r48(6'd8, 32'h1AA, 7'h00, 1'b1), 48, 5, -1);
      exp_resp = 128'h1AA;
      checks++;
      if (obs_tx !== 48'h48000001AA87 || !obs_oe_ok) begin
         errors++; $display("FAIL cmd8_frame: got %h oe_ok=%0d expected 48000001aa87 oe_ok=1", obs_tx, obs_oe_ok);
      end
      checks++;
      if (obs_ev_cyc != 102 || obs_ev !== 5'b10000 || obs_ev_cnt != 1 || obs_idle != 103) begin
         errors++; $display("FAIL cmd8_done: got cyc=%0d ev=%b n=%0d idle=%0d expected 102 10000 1 103",
                            obs_ev_cyc, obs_ev, obs_ev_cnt, obs_idle);
      end
      checks++;
      if (obs_resp !== exp_resp) begin
         errors++; $display("FAIL cmd8_resp: got %h expected %h", obs_resp, exp_resp);
      end
   endtask

   task automatic test_faults;
      logic [5:0] f_idx  [4] = '{6'd8, 6'd8, 6'd9, 6'd9};
      logic [1:0] f_typ  [4] = '{2'd1, 2'd1, 2'd1, 2'd3};
      logic [6:0] f_flip [4] = '{7'h01, 7'h00, 7'h00, 7'h00};
      logic       f_end  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [4:0] f_exp  [4] = '{5'b10010, 5'b10100, 5'b11000, 5'b10000};
      for (int i = 0; i < 4; i++) begin
         run_cmd(6'd8, 32'h1AA, f_typ[i], mk_r48(f_idx[i], 32'h1AA, f_flip[i], f_end[i]), 48, 5, -1);
         exp_resp = 128'h1AA;
         checks++;
         if (obs_ev_cyc != 102 || obs_ev !== f_exp[i] || obs_ev_cnt != 1 || obs_resp !== exp_resp) begin
            errors++; $display("FAIL fault_%0d: got cyc=%0d ev=%b n=%0d resp=%h expected 102 %b 1 %h",
                               i, obs_ev_cyc, obs_ev, obs_ev_cnt, obs_resp, f_exp[i], exp_resp);
         end
      end
   endtask

   task automatic test_timeout;
      run_cmd(6'd55, 32'hDEAD_BEEF, 2'd1, '0, 0, 0, -1);
      checks++;
      if (obs_ev_cyc != 48 + TO + 1 || obs_ev !== 5'b00001 || obs_ev_cnt != 1) begin
         errors++; $display("FAIL timeout_pulse: got cyc=%0d ev=%b n=%0d expected %0d 00001 1",
                            obs_ev_cyc, obs_ev, obs_ev_cnt, 48 + TO + 1);
      end
      checks++;
      if (obs_idle != 48 + TO + 2 || obs_resp !== exp_resp) begin
         errors++; $display("FAIL timeout_idle: got idle=%0d resp=%h expected %0d %h",
                            obs_idle, obs_resp, 48 + TO + 2, exp_resp);
      end
   endtask

   task automatic test_r136;
      logic [135:0] v;
      v = mk_r136(128'h400E00325B5900003B377F800A4040DF, 7'h00, 1'b1);
      run_cmd(6'd9, 32'h0001_0000, 2'd2, v, 136, 3, 120);
      exp_resp = v[127:0];
      checks++;
      if (obs_ev_cyc != 188 || obs_ev !== 5'b10000 || obs_ev_cnt != 1 || obs_idle != 189) begin
         errors++; $display("FAIL r136_done: got cyc=%0d ev=%b n=%0d idle=%0d expected 188 10000 1 189",
                            obs_ev_cyc, obs_ev, obs_ev_cnt, obs_idle);
      end
      checks++;
      if (obs_resp !== exp_resp || resp !== exp_resp) begin
         errors++; $display("FAIL r136_resp: got %h expected %h", obs_resp, exp_resp);
      end
   endtask

   task automatic test_sd_rst;
      int         ev_n;
      bit         bad_oe;
      logic [5:0] idx;
      logic [31:0] arg;
      cmd_index = 6'd17; cmd_arg = 32'h1234_5678; resp_type = 2'd1; cmd_in = 1'b1; cmd_start = 1'b1;
      @(posedge sd_clk); #1;
      cmd_start = 1'b0;
      repeat (20) begin
         @(posedge sd_clk); #1;
      end
      cmd_sd_rst = 1'b1; cmd_start = 1'b1; cmd_index = 6'd2; resp_type = 2'd0;
      @(posedge sd_clk); #1;
      cmd_sd_rst = 1'b0; cmd_start = 1'b0;
      checks++;
      if (cmd_oe !== 1'b0 || cmd_out !== 1'b1 || cmd_busy !== 1'b0) begin
         errors++; $display("FAIL sdrst_abort: got oe=%b out=%b busy=%b expected 0 1 0", cmd_oe, cmd_out, cmd_busy);
      end
      ev_n = 0; bad_oe = 1'b0;
      repeat (130) begin
         if ({done_ev, idx_ev, end_ev, crc_ev, to_ev} != 5'b0) ev_n++;
         if (cmd_oe !== 1'b0 || cmd_busy !== 1'b0) bad_oe = 1'b1;
         @(posedge sd_clk); #1;
      end
      checks++;
      if (ev_n != 0 || bad_oe || resp !== exp_resp) begin
         errors++; $display("FAIL sdrst_quiet: got events=%0d active=%0d resp=%h expected 0 0 %h",
                            ev_n, bad_oe, resp, exp_resp);
      end
      idx = 6'($urandom_range(0, 63)); arg = $urandom;
      run_cmd(idx, arg, 2'd0, '0, 0, 0, -1);
      checks++;
      if (obs_tx !== model_frame(idx, arg) || !obs_oe_ok || obs_ev !== 5'b10000 || obs_ev_cyc != 49) begin
         errors++; $display("FAIL sdrst_fresh: got %h ev=%b cyc=%0d expected %h 10000 49",
                            obs_tx, obs_ev, obs_ev_cyc, model_frame(idx, arg));
      end
   endtask

   task automatic test_back_to_back;
      logic [47:0] tx;
      bit          ok;
      int          n;
      cmd_index = 6'd1; cmd_arg = 32'h0; resp_type = 2'd0; cmd_start = 1'b1;
      @(posedge sd_clk); #1;
      cmd_start = 1'b0;
      repeat (49) begin
         @(posedge sd_clk); #1;
      end
      checks++;
      if (done_ev !== 1'b1) begin
         errors++; $display("FAIL b2b_first_done: got %b expected 1", done_ev);
      end
      cmd_index = 6'd52; cmd_arg = 32'hCAFE_F00D; cmd_start = 1'b1;
      @(posedge sd_clk); #1;
      cmd_start = 1'b0;
      ok = (cmd_busy === 1'b1);
      for (int k = 0; k < 48; k++) begin
         if (k > 0) begin
            @(posedge sd_clk); #1;
         end
         tx[47-k] = cmd_out;
         if (cmd_oe !== 1'b1) ok = 1'b0;
      end
      checks++;
      if (tx !== model_frame(6'd52, 32'hCAFE_F00D) || !ok) begin
         errors++; $display("FAIL b2b_second_frame: got %h ok=%0d expected %h ok=1",
                            tx, ok, model_frame(6'd52, 32'hCAFE_F00D));
      end
      n = 0;
      while (cmd_busy === 1'b1 && n < 20) begin
         @(posedge sd_clk); #1;
         n++;
      end
      checks++;
      if (n != 3) begin
         errors++; $display("FAIL b2b_drain: got %0d edges to idle expected 3", n);
      end
   endtask

   task automatic test_random;
      logic [5:0]   idx, ridx;
      logic [31:0]  arg, rarg;
      logic [1:0]   typ;
      logic [135:0] v;
      logic [127:0] csd;
      logic [6:0]   flip;
      logic [4:0]   ev_exp;
      int           gap, fault, len, cyc_exp;
      for (int it = 0; it < 14; it++) begin
         idx = 6'($urandom_range(0, 63)); arg = $urandom; typ = 2'($urandom_range(0, 3));
         gap = $urandom_range(0, 6); fault = $urandom_range(0, 3);
         rarg = $urandom; ridx = idx;
         csd = {$urandom, $urandom, $urandom, $urandom};
         flip = (fault == 1) ? 7'(1 << $urandom_range(0, 6)) : 7'h00;
         if (fault == 3) ridx = idx ^ 6'($urandom_range(1, 63));
         if (typ == 2'd2) begin
            v = mk_r136(csd, flip, fault != 2); len = 136;
         end else begin
            v = mk_r48(ridx, rarg, flip, fault != 2); len = 48;
         end
         if (typ == 2'd0) begin
            len = 0; ev_exp = 5'b10000; cyc_exp = 49;
         end else begin
            ev_exp  = {1'b1, typ == 2'd1 && fault == 3, fault == 2, typ != 2'd3 && fault == 1, 1'b0};
            cyc_exp = 49 + gap + len;
            exp_resp = (typ == 2'd2) ? v[127:0] : {96'd0, v[39:8]};
         end
         run_cmd(idx, arg, typ, v, len, gap, -1);
         checks++;
         if (obs_tx !== model_frame(idx, arg) || !obs_oe_ok) begin
            errors++; $display("FAIL rand_%0d_frame: got %h oe_ok=%0d expected %h",
                               it, obs_tx, obs_oe_ok, model_frame(idx, arg));
         end
         checks++;
         if (obs_ev_cyc != cyc_exp || obs_ev !== ev_exp || obs_ev_cnt != 1 || obs_idle != cyc_exp + 1
             || obs_resp !== exp_resp) begin
            errors++; $display("FAIL rand_%0d_resp: got cyc=%0d ev=%b n=%0d idle=%0d resp=%h expected %0d %b 1 %0d %h",
                               it, obs_ev_cyc, obs_ev, obs_ev_cnt, obs_idle, obs_resp,
                               cyc_exp, ev_exp, cyc_exp + 1, exp_resp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cmd0();
      test_cmd8();
      test_faults();
      test_timeout();
      test_r136();
      test_sd_rst();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/sdio_cmd_engine.md
# sdio_cmd_engine

SD-domain command engine that serialises one SD command frame onto the CMD line and collects the card's response. It checks the response for timeout, CRC7, end-bit and index errors. It is the direct upstream producer of the command-side `*_event` pulses consumed by the interrupt/error flag block (`cmd_done_event`, `cmd_index_err_event`, `cmd_end_err_event`, `cmd_crc_err_event`, `cmd_timeout_err_event`). It shares `cmd_start` and `cmd_sd_rst` with that block.

## Interface
- TIMEOUT_CYCLES, 64, sd_clk edges spent in WAIT without a response start bit before a timeout is declared (≥1).
- rstn  in  1  reset, asynchronous, active-low
- sd_clk  in  1  SD clock; all logic on its rising edge
- cmd_sd_rst  in  1  synchronous soft reset of the command path
- cmd_start  in  1  one-cycle pulse that launches a command; accepted only in IDLE
- cmd_index  in  6  command index; captured on accepted cmd_start
- cmd_arg  in  32  command argument; captured on accepted cmd_start
- resp_type  in  2  response type; captured on accepted cmd_start
  - 0: none
  - 1: R48, CRC and index checked
  - 2: R136, CRC checked
  - 3: R48, no CRC or index check (R3)
- cmd_in  in  1  sampled CMD line
- cmd_out  out  1  driven CMD bit
- cmd_oe  out  1  CMD output enable
- resp  out  128  response payload
  - R48: [31:0] = response bits 39:8, [127:32] = 0
  - R136: [127:0] = response bits 127:0
- cmd_busy  out  1  high in any state other than IDLE
- cmd_done_event, cmd_index_err_event, cmd_end_err_event, cmd_crc_err_event, cmd_timeout_err_event  out  1 each  one-cycle pulses

## Operation
- States: IDLE, TX, WAIT, RX, FIN.
- IDLE + cmd_start → TX. Capture index, arg and type. Preload a 48-bit shift register with:
  - bit 47: start bit = 0
  - bit 46: transmission bit = 1
  - bits 45:40: index
  - bits 39:8: arg
  - bits 7:1: CRC7
  - bit 0: end bit = 1
- CRC7 polynomial x^7+x^3+1, init 0, computed over frame bits 47:8, MSB first. The TX CRC is computed combinationally or by a serial pre-pass; the frame on the wire must be exact either way.
- TX: 48 bits MSB-first, one per edge, cmd_oe=1. After the end bit:
  - resp_type 0 → FIN.
  - otherwise → WAIT, with timeout counter cleared.
- WAIT: cmd_oe=0, cmd_out=1. Sample cmd_in each edge.
  - cmd_in=0 → RX; the start bit counts as received bit 1.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES → FIN with timeout flagged.
- RX: shift cmd_in in until 48 bits (types 1 and 3) or 136 bits (type 2) are received, then → FIN.
  - Running CRC7 covers bits 47:8 (R48) or bits 127:8 (R136).
- FIN (exactly one cycle), flags evaluated from the captured frame:
  - Timeout case: cmd_timeout_err_event=1 only. cmd_done_event stays 0. resp unchanged.
  - Otherwise:
    - cmd_done_event=1.
    - cmd_end_err_event = (end bit ≠ 1).
    - cmd_crc_err_event = (type 1 or 2) and (received bits 7:1 ≠ computed CRC7).
    - cmd_index_err_event = (type 1) and (bits 45:40 ≠ captured index).
    - Any combination of error pulses may coincide with done.
    - resp updated (type 0 leaves resp unchanged).
- FIN → IDLE.
- cmd_start while busy: ignored, no state change.
- cmd_sd_rst (synchronous, highest priority, wins over a simultaneous cmd_start):
  - Next edge: IDLE, cmd_oe=0, cmd_out=1, counters cleared.
  - No event pulses for the aborted command. resp retained.
- Counters:
  - Bit counter 8 bits, max 136.
  - Timeout counter $clog2(TIMEOUT_CYCLES+1) bits, saturating at the compare point.

## Timing
- Reset values:
  - state IDLE
  - cmd_out=1, cmd_oe=0
  - resp=0
  - cmd_busy=0
  - all events 0
- cmd_start sampled at edge T0:
  - From T0: cmd_oe=1, cmd_out=0 (start bit). Frame bit 47−k is valid after edge T0+k, k=0..47.
  - cmd_busy=1 after T0.
- After edge T0+48: cmd_oe=0, cmd_out=1. First WAIT sample at edge T0+49.
- No timeout: a start bit never seen in WAIT gives cmd_timeout_err_event high for the single cycle after edge T0+48+TIMEOUT_CYCLES+1.
- Response: last bit sampled at edge E → events and resp valid after edge E+1 for one cycle → IDLE and cmd_busy=0 after edge E+2.
- resp_type 0: cmd_done_event high after edge T0+49. A new cmd_start is accepted at edge T0+50 or later.
- All outputs are registered.

## Test plan
- CMD0, arg 0x00000000, type 0 → cmd_out sequence equals 0x400000000095 MSB-first on 48 consecutive cycles with cmd_oe=1. Then done pulse after T0+49, no error pulses.
- CMD8, arg 0x000001AA, type 1 → TX frame 0x48000001AA87. Bench returns a correct R7 (index 8, arg 0x1AA, model CRC) after a 5-cycle gap → done only, resp=0x000001AA.
- Same as above but with each fault in turn → done plus only the matching error pulse:
  - response CRC bit 1 flipped → crc_err
  - end bit 0 → end_err
  - index 9 → index_err
  - index 9 with type 3 → no error
- Type 1 with cmd_in held 1, TIMEOUT_CYCLES=64 → timeout pulse exactly 64 WAIT edges after release, no done, busy falls next cycle.
- Type 2 R136 with model CSD 0x400E00325B5900003B377F800A4040DF → resp equals the 128 bits, no errors. Second cmd_start pulsed mid-RX is ignored.
- cmd_sd_rst asserted mid-TX (bit 20) together with cmd_start → IDLE next edge, cmd_oe=0, no events. Fresh cmd_start afterwards sends a complete, correct frame.
